// File: rtl/alu_exec_seq.sv
// ---------------------------------------------------------------------------
// alu_exec_seq
// Execute-stage sequencer wrapped around an external, purely combinational
// 8-bit ALU. One decoded instruction is accepted per handshake, its operands
// are read from an internal register file, the ALU result is captured and
// written back to reg[rd], and the architectural C/Z flags are updated.
//
// Sequence: IDLE -> READ -> EXEC -> WB -> IDLE (one instruction per 4 cycles).
//
// Parameters:
//   NUM_REGS    : register-file depth (2, 4 or 8); upper index bits ignored
//   LOGIC_CLR_C : 1 = AND/OR/NOT/XOR write the ALU carry into C,
//                 0 = those ops leave C untouched (Z always written)
//
// Optional feature (macro ALU_EXEC_RETIRE_CNT_EN):
//   adds output retire_cnt[15:0], a wrapping count of write-back cycles.
//
// Ports:
//   clk, rst_n         : clock (rising edge), async active-low reset
//   in_valid/in_ready  : instruction handshake (ready only in IDLE)
//   in_op/rd/rs        : opcode, destination/A register, B register
//   in_use_imm/in_imm  : select immediate as B operand, immediate value
//   alu_op/alu_a/alu_b : registered drive of the ALU inputs
//   alu_out/carry/zero : ALU results
//   done               : one-cycle pulse in the write-back cycle
//   flag_c/flag_z      : architectural carry / zero flags
//   dbg_addr/dbg_data  : combinational debug read of the register file
//   retire_cnt         : (optional) retired-instruction counter
// ---------------------------------------------------------------------------
module alu_exec_seq #(
    parameter int NUM_REGS    = 8,
    parameter bit LOGIC_CLR_C = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [2:0]  in_rd,
    input  logic [2:0]  in_rs,
    input  logic        in_use_imm,
    input  logic [7:0]  in_imm,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        done,
    output logic        flag_c,
    output logic        flag_z,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
`ifdef ALU_EXEC_RETIRE_CNT_EN
    ,
    output logic [15:0] retire_cnt
`endif
);

    localparam int IDX_W = (NUM_REGS <= 2) ? 1 : $clog2(NUM_REGS);

    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // True for the bitwise ops, whose carry handling is configurable.
    function automatic logic is_logic_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_AND, OP_OR, OP_NOT, OP_XOR: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    state_t             state_r;
    state_t             next_state_s;

    logic               accept_s;
    logic               ready_nxt_s;
    logic               done_nxt_s;
    logic               in_ready_r;
    logic               done_r;

    // Instruction fields latched at acceptance
    logic [2:0]         hold_op_r;
    logic [IDX_W-1:0]   hold_rd_r;
    logic [IDX_W-1:0]   hold_rs_r;
    logic               hold_use_imm_r;
    logic [7:0]         hold_imm_r;

    // ALU drive and captured results
    logic [2:0]         alu_op_r;
    logic [7:0]         alu_a_r;
    logic [7:0]         alu_b_r;
    logic [7:0]         res_out_r;
    logic               res_c_r;
    logic               res_z_r;

    logic [7:0]         regs_r [NUM_REGS];
    logic               flag_c_r;
    logic               flag_z_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_READ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ: next_state_s = ST_EXEC;
            ST_EXEC: next_state_s = ST_WB;
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: ready/done are registered, so decode from the next state
    always_comb begin
        accept_s    = in_valid & in_ready_r;
        ready_nxt_s = 1'b0;
        done_nxt_s  = 1'b0;
        case (next_state_s)
            ST_IDLE: ready_nxt_s = 1'b1;
            ST_WB:   done_nxt_s  = 1'b1;
            default: begin
                ready_nxt_s = 1'b0;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // Registered handshake and completion outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= ready_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    // Holding registers, ALU operand drive and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_op_r      <= 3'd0;
            hold_rd_r      <= '0;
            hold_rs_r      <= '0;
            hold_use_imm_r <= 1'b0;
            hold_imm_r     <= 8'h00;
            alu_op_r       <= 3'd0;
            alu_a_r        <= 8'h00;
            alu_b_r        <= 8'h00;
            res_out_r      <= 8'h00;
            res_c_r        <= 1'b0;
            res_z_r        <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && accept_s) begin
                hold_op_r      <= in_op;
                hold_rd_r      <= in_rd[IDX_W-1:0];
                hold_rs_r      <= in_rs[IDX_W-1:0];
                hold_use_imm_r <= in_use_imm;
                hold_imm_r     <= in_imm;
            end
            // Both operands come from the pre-write array, so rd == rs is safe.
            if (state_r == ST_READ) begin
                alu_op_r <= hold_op_r;
                alu_a_r  <= regs_r[hold_rd_r];
                alu_b_r  <= hold_use_imm_r ? hold_imm_r : regs_r[hold_rs_r];
            end
            if (state_r == ST_EXEC) begin
                res_out_r <= alu_out;
                res_c_r   <= alu_carry;
                res_z_r   <= alu_zero;
            end
        end
    end

    // Register-file write-back and architectural flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 8'h00;
            end
            flag_c_r <= 1'b0;
            flag_z_r <= 1'b0;
        end else if (state_r == ST_WB) begin
            regs_r[hold_rd_r] <= res_out_r;
            flag_z_r          <= res_z_r;
            if (!is_logic_op(hold_op_r) || (LOGIC_CLR_C != 1'b0)) begin
                flag_c_r <= res_c_r;
            end else begin
                flag_c_r <= flag_c_r;
            end
        end else begin
            flag_c_r <= flag_c_r;
            flag_z_r <= flag_z_r;
        end
    end

`ifdef ALU_EXEC_RETIRE_CNT_EN
    logic [15:0] retire_cnt_r;

    // Retired-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= 16'h0000;
        end else if (state_r == ST_WB) begin
            retire_cnt_r <= retire_cnt_r + 16'h0001;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign retire_cnt = retire_cnt_r;
`endif

    assign in_ready = in_ready_r;
    assign done     = done_r;
    assign alu_op   = alu_op_r;
    assign alu_a    = alu_a_r;
    assign alu_b    = alu_b_r;
    assign flag_c   = flag_c_r;
    assign flag_z   = flag_z_r;
    // Combinational debug read: shows the old value during the WB cycle.
    assign dbg_data = regs_r[dbg_addr[IDX_W-1:0]];

endmodule
